uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 39 +++
 rtl/uart_tx_framer.sv | 138 +++++++++++++
 tb/tb_uart_tx_framer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit framer: FSM state codes,
// parity-type encoding and the legal payload-width range.
package uart_pkg;

  // FSM state codes (also visible on the framer's debug state output)
  typedef logic [2:0] uart_state_t;
  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Parity type selector values
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Legal payload width range
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. While running it counts CLKS_PER_BIT cycles per
// bit and pulses o_bit_done in the last cycle of each bit, reloading itself
// at that boundary. i_restart reloads it to start a fresh bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_restart,
  input  logic i_run,
  output logic o_bit_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);

  generate
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("uart_bit_timer: CLKS_PER_BIT must be >= 1");
    end
  endgenerate

  logic [CW-1:0] r_count;

  assign o_bit_done = i_run && (r_count == '0);

  // Count down within a bit; reload on restart or at each bit boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_restart || o_bit_done) begin
      r_count <= RELOAD;
    end else if (i_run) begin
      r_count <= r_count - ONE;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word on a valid/ready handshake and
// serialises it as start bit, DATA_W data bits (LSB first), optional parity
// and one or two stop bits on a registered, idle-high line.
//
// Handshake: a word is taken on any rising clk edge where data_valid and
// ready are both 1; data_in, par_en, par_typ and stop2 are captured on that
// edge. ready is high in IDLE and in the final cycle of the last stop bit,
// so a word offered then starts its start bit with no idle gap. Inputs seen
// while ready is low are ignored.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic              stop2,
  output logic              ready,
  output logic              busy,
  output logic              tx_out,
  output logic [2:0]        dbg_state
);

  generate
    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
      $error("uart_tx_framer: DATA_W must be within 5..9");
    end
  endgenerate

  localparam logic [3:0] LAST_IDX = 4'(DATA_W - 1);

  uart_state_t       r_state;
  logic              r_tx;
  logic [DATA_W-1:0] r_data;
  logic              r_par;
  logic              r_par_en;
  logic              r_stop2;
  logic [3:0]        r_bit_idx;
  logic              r_stop_idx;
  logic              r_armed;

  logic w_bit_done;
  logic w_last_stop;
  logic w_accept;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_restart  (w_accept),
    .i_run      (r_state != ST_IDLE),
    .o_bit_done (w_bit_done)
  );

  // Final cycle of the last stop bit (second one when two are configured)
  assign w_last_stop = (r_state == ST_STOP) && w_bit_done && (r_stop_idx || !r_stop2);
  // r_armed keeps ready low during reset and until the first clk after it
  assign ready     = r_armed && ((r_state == ST_IDLE) || w_last_stop);
  assign w_accept  = data_valid && ready;
  assign busy      = (r_state != ST_IDLE);
  assign tx_out    = r_tx;
  assign dbg_state = r_state;

  // Frame sequencer: captures on accept, steps bit by bit on timer pulses,
  // and registers the line value for the bit being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tx       <= 1'b1;
      r_data     <= '0;
      r_par      <= 1'b0;
      r_par_en   <= 1'b0;
      r_stop2    <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_state    <= ST_START;
        r_tx       <= 1'b0;
        r_data     <= data_in;
        r_par      <= (par_typ == PAR_ODD) ? ~^data_in : ^data_in;
        r_par_en   <= par_en;
        r_stop2    <= stop2;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_bit_done) begin
        case (r_state)
          ST_START: begin
            r_state   <= ST_DATA;
            r_tx      <= r_data[0];
            r_bit_idx <= '0;
          end
          ST_DATA: begin
            if (r_bit_idx == LAST_IDX) begin
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state    <= ST_STOP;
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
              end
            end else begin
              // Shift so the next payload bit is always at index 1 -> 0
              r_bit_idx <= r_bit_idx + 4'd1;
              r_data    <= r_data >> 1;
              r_tx      <= r_data[1];
            end
          end
          ST_PARITY: begin
            r_state    <= ST_STOP;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end
          ST_STOP: begin
            r_tx <= 1'b1;
            if (w_last_stop) begin
              r_state <= ST_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: instance A (DATA_W=8, CLKS_PER_BIT=4) and
// instance B (DATA_W=5, CLKS_PER_BIT=1). Expected line traces are built
// from frame rules as per-cycle {tx_out, busy, ready} triples.
module tb_uart_tx_framer;

  logic       clk;
  logic       rst;

  logic [7:0] a_data;
  logic       a_valid, a_pe, a_pt, a_s2;
  logic       a_ready, a_busy, a_tx;
  logic [2:0] a_dbg;

  logic [4:0] b_data;
  logic       b_valid, b_pe, b_pt, b_s2;
  logic       b_ready, b_busy, b_tx;
  logic [2:0] b_dbg;

  int checks;
  int failures;

  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];

  uart_tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_data), .data_valid(a_valid),
    .par_en(a_pe), .par_typ(a_pt), .stop2(a_s2),
    .ready(a_ready), .busy(a_busy), .tx_out(a_tx), .dbg_state(a_dbg)
  );

  uart_tx_framer #(.DATA_W(5), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_data), .data_valid(b_valid),
    .par_en(b_pe), .par_typ(b_pt), .stop2(b_s2),
    .ready(b_ready), .busy(b_busy), .tx_out(b_tx), .dbg_state(b_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit sel, input logic [8:0] d, input logic v,
                       input logic pe, input logic pt, input logic s2);
    if (sel) begin
      b_data = d[4:0]; b_valid = v; b_pe = pe; b_pt = pt; b_s2 = s2;
    end else begin
      a_data = d[7:0]; a_valid = v; a_pe = pe; a_pt = pt; a_s2 = s2;
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) b_valid = v;
    else     a_valid = v;
  endtask

  function automatic logic [2:0] line_state(input bit sel);
    return sel ? {b_tx, b_busy, b_ready} : {a_tx, a_busy, a_ready};
  endfunction

  task automatic wait_ready(input bit sel);
    int t;
    logic [2:0] s;
    t = 0;
    s = line_state(sel);
    while (s[0] !== 1'b1 && t < 200) begin
      @(negedge clk);
      s = line_state(sel);
      t++;
    end
    checks++;
    if (s[0] !== 1'b1) begin
      failures++;
      $display("FAIL wait_ready(sel=%0d): ready=%b after %0d cycles, required 1", sel, s[0], t);
    end
  endtask

  // Waits for ready, then presents a word with data_valid=1
  task automatic offer(input bit sel, input logic [8:0] d,
                       input logic pe, input logic pt, input logic s2);
    wait_ready(sel);
    drive(sel, d, 1'b1, pe, pt, s2);
  endtask

  // Records {tx,busy,ready} at n falling edges; drops data_valid after sample drop_at
  task automatic sample(input bit sel, input int n, input int drop_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs_q.push_back(line_state(sel));
      if (i == drop_at) set_valid(sel, 1'b0);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void add_frame(input int dw, input int cpb, input logic [8:0] d,
                                    input logic pe, input logic pt, input logic s2);
    logic bits[$];
    logic p;
    p = pt;
    bits.push_back(1'b0);
    for (int i = 0; i < dw; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (pe) bits.push_back(p);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < cpb; c++)
        exp_q.push_back({bits[b], 1'b1, (b == bits.size() - 1 && c == cpb - 1)});
  endfunction

  function automatic void add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b101);
  endfunction

  function automatic void clear_q();
    exp_q.delete();
    obs_q.delete();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if ({a_tx, a_busy, a_ready} !== 3'b100) begin
      failures++;
      $display("FAIL reset_a {tx,busy,ready}=%b required 100", {a_tx, a_busy, a_ready});
    end
    checks++;
    if ({b_tx, b_busy, b_ready} !== 3'b100) begin
      failures++;
      $display("FAIL reset_b {tx,busy,ready}=%b required 100", {b_tx, b_busy, b_ready});
    end
    rst = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_ready_early ready=%b required 0", a_ready);
    end
    @(negedge clk);
    checks++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reset_release_a {tx,busy,ready}=%b required 101", {a_tx, a_busy, a_ready});
    end
    checks++;
    if ({b_tx, b_busy, b_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reset_release_b {tx,busy,ready}=%b required 101", {b_tx, b_busy, b_ready});
    end
  endtask

  task automatic test_basic();
    logic [9:0] pat;
    int nb;
    pat = 10'b1101001010;
    clear_q();
    add_frame(8, 4, 9'h0A5, 1'b0, 1'b0, 1'b0);
    add_idle(4);
    offer(0, 9'h0A5, 1'b0, 1'b0, 1'b0);
    sample(0, exp_q.size(), 0);
    nb = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      nb += int'(obs_q[i][1]);
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_a5 cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (obs_q[b*4+2][2] !== pat[b]) begin
        failures++;
        $display("FAIL basic_a5_bit %0d tx=%b required %b", b, obs_q[b*4+2][2], pat[b]);
      end
    end
    checks++;
    if (nb != 40) begin
      failures++;
      $display("FAIL basic_a5_busy_len busy cycles=%0d required 40", nb);
    end
  endtask

  task automatic test_parity();
    int nb;
    for (int pt = 0; pt < 2; pt++) begin
      clear_q();
      add_frame(8, 4, 9'h0A5, 1'b1, 1'(pt), 1'b0);
      add_idle(2);
      offer(0, 9'h0A5, 1'b1, 1'(pt), 1'b0);
      sample(0, exp_q.size(), 0);
      nb = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        nb += int'(obs_q[i][1]);
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL parity_pt%0d cycle %0d {tx,busy,ready}=%b required %b", pt, i, obs_q[i], exp_q[i]);
        end
      end
      checks++;
      if (obs_q[37][2] !== 1'(pt)) begin
        failures++;
        $display("FAIL parity_pt%0d_bit tx=%b required %0d", pt, obs_q[37][2], pt);
      end
      checks++;
      if (nb != 44) begin
        failures++;
        $display("FAIL parity_pt%0d_len busy cycles=%0d required 44", pt, nb);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    clear_q();
    add_frame(8, 4, 9'h000, 1'b1, 1'b0, 1'b1);
    add_frame(8, 4, 9'h0FF, 1'b0, 1'b0, 1'b0);
    add_idle(4);
    offer(0, 9'h000, 1'b1, 1'b0, 1'b1);
    sample(0, 1, -1);
    drive(0, 9'h0FF, 1'b1, 1'b0, 1'b0, 1'b0);
    sample(0, exp_q.size() - 1, 47);
    nb = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      nb += int'(obs_q[i][1]);
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (obs_q[48] !== 3'b010) begin
      failures++;
      $display("FAIL b2b_no_gap cycle 48 {tx,busy,ready}=%b required 010", obs_q[48]);
    end
    checks++;
    if (nb != 88) begin
      failures++;
      $display("FAIL b2b_len busy cycles=%0d required 88", nb);
    end
  endtask

  task automatic test_ignore_busy();
    clear_q();
    add_frame(8, 4, 9'h05A, 1'b0, 1'b0, 1'b0);
    add_idle(8);
    offer(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    sample(0, 10, 0);
    drive(0, 9'h03C, 1'b1, 1'b1, 1'b1, 1'b1);
    sample(0, 20, -1);
    drive(0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0);
    sample(0, exp_q.size() - 30, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ignore_busy cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    add_frame(8, 4, 9'h0F0, 1'b0, 1'b0, 1'b0);
    offer(0, 9'h0F0, 1'b0, 1'b0, 1'b0);
    sample(0, 18, 0);
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_prefix cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({a_tx, a_busy, a_ready} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_async {tx,busy,ready}=%b required 100", {a_tx, a_busy, a_ready});
    end
    @(negedge clk);
    checks++;
    if ({a_tx, a_busy, a_ready} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_hold {tx,busy,ready}=%b required 100", {a_tx, a_busy, a_ready});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_tx, a_busy, a_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reset_mid_release {tx,busy,ready}=%b required 101", {a_tx, a_busy, a_ready});
    end
    clear_q();
    add_frame(8, 4, 9'h081, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    offer(0, 9'h081, 1'b0, 1'b0, 1'b0);
    sample(0, exp_q.size(), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_mid_0x81 cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_small();
    logic [6:0] pat;
    pat = 7'b1101010;
    clear_q();
    add_frame(5, 1, 9'h015, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    offer(1, 9'h015, 1'b0, 1'b0, 1'b0);
    sample(1, exp_q.size(), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL small_15 cycle %0d {tx,busy,ready}=%b required %b", i, obs_q[i], exp_q[i]);
      end
    end
    for (int b = 0; b < 7; b++) begin
      checks++;
      if (obs_q[b][2] !== pat[b]) begin
        failures++;
        $display("FAIL small_15_bit %0d tx=%b required %b", b, obs_q[b][2], pat[b]);
      end
    end
  endtask

  task automatic test_random();
    bit sel;
    int dw, cpb, gap, len1;
    logic [8:0] d1, d2;
    logic pe1, pt1, s21, pe2, pt2, s22;
    bit b2b;
    for (int k = 0; k < 24; k++) begin
      sel = 1'($urandom_range(0, 1));
      dw  = sel ? 5 : 8;
      cpb = sel ? 1 : 4;
      d1  = 9'($urandom_range(0, (1 << dw) - 1));
      d2  = 9'($urandom_range(0, (1 << dw) - 1));
      pe1 = 1'($urandom_range(0, 1)); pt1 = 1'($urandom_range(0, 1)); s21 = 1'($urandom_range(0, 1));
      pe2 = 1'($urandom_range(0, 1)); pt2 = 1'($urandom_range(0, 1)); s22 = 1'($urandom_range(0, 1));
      b2b = 1'($urandom_range(0, 1));
      gap = $urandom_range(1, 3);
      len1 = (2 + dw + int'(pe1) + int'(s21)) * cpb;
      clear_q();
      add_frame(dw, cpb, d1, pe1, pt1, s21);
      if (b2b) add_frame(dw, cpb, d2, pe2, pt2, s22);
      add_idle(gap);
      offer(sel, d1, pe1, pt1, s21);
      if (b2b) begin
        sample(sel, 1, -1);
        drive(sel, d2, 1'b1, pe2, pt2, s22);
        sample(sel, exp_q.size() - 1, len1 - 1);
      end else begin
        sample(sel, exp_q.size(), 0);
      end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random k=%0d sel=%0d d=%h b2b=%0d cycle %0d {tx,busy,ready}=%b required %b",
                   k, sel, d1, b2b, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_small();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
